// File: rtl/flag_pkg.sv
// Shared types for the NZCV flag write controller:
// condition codes, flag bit positions and FSM state encoding.
package flag_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef logic [0:0] fwc_state_e;

    localparam fwc_state_e ST_IDLE = 1'b0;
    localparam fwc_state_e ST_PEND = 1'b1;

endpackage

// File: rtl/flag_write_ctrl_if.sv
// Requester, branch and flag-register signals of the flag write controller.
// master: pipeline/flag-register side, slave: the controller.
interface flag_write_ctrl_if;

    logic       alu_setflags;
    logic [3:0] alu_flags;
    logic       mc_issue;
    logic       mc_done;
    logic [3:0] mc_flags;
    logic       sw_wr;
    logic [3:0] sw_flags;
    logic       br_req;
    logic [3:0] br_cond;
    logic [3:0] flag_q;
    logic       flag_wr;
    logic [3:0] flag_din;
    logic       stall;
    logic       br_valid;
    logic       br_taken;
    logic       err_collision;
    logic       err_timeout;

    modport master (
        output alu_setflags, alu_flags,
        output mc_issue, mc_done, mc_flags,
        output sw_wr, sw_flags,
        output br_req, br_cond, flag_q,
        input  flag_wr, flag_din, stall,
        input  br_valid, br_taken,
        input  err_collision, err_timeout
    );

    modport slave (
        input  alu_setflags, alu_flags,
        input  mc_issue, mc_done, mc_flags,
        input  sw_wr, sw_flags,
        input  br_req, br_cond, flag_q,
        output flag_wr, flag_din, stall,
        output br_valid, br_taken,
        output err_collision, err_timeout
    );

endinterface

// File: rtl/flag_write_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator over NZCV flags.
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       taken_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        taken_o = 1'b1;
        case (cond_e'(cond_i))
            COND_EQ: taken_o = z;
            COND_NE: taken_o = ~z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = ~c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = ~n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = ~v;
            COND_HI: taken_o = c & ~z;
            COND_LS: taken_o = ~c | z;
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = ~z & (n == v);
            COND_LE: taken_o = z | (n != v);
            default: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_write_ctrl.sv
// NZCV flag write scheduler and branch-condition evaluator.
// FLAG_BYPASS_EN: branches in the mc_done cycle use mc_flags without stalling.
module flag_write_ctrl
    import flag_pkg::*;
#(
    parameter int MC_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    flag_write_ctrl_if.slave  bus
);

    localparam int CW = $clog2(MC_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

    fwc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_to_q, err_to_d;

    logic       pend;
    logic       mc_fin;
    logic       br_hold;
    logic       stall;
    logic       taken;
    logic [3:0] eval_flags;

    assign pend   = (state_q == ST_PEND);
    assign mc_fin = pend & bus.mc_done;

`ifdef FLAG_BYPASS_EN
    // A branch landing on the completion cycle sees the new flags directly.
    assign br_hold    = bus.br_req & ~bus.mc_done;
    assign eval_flags = mc_fin ? bus.mc_flags : bus.flag_q;
`else
    assign br_hold    = bus.br_req;
    assign eval_flags = bus.flag_q;
`endif

    assign stall = pend & (bus.alu_setflags | bus.sw_wr
                         | bus.mc_issue | br_hold);

    cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (bus.br_cond),
        .taken_o (taken)
    );

    assign bus.stall       = stall;
    assign bus.br_valid    = bus.br_req & ~stall;
    assign bus.br_taken    = bus.br_req & ~stall & taken;
    assign bus.err_timeout = err_to_q;

    always_comb begin
        bus.flag_wr       = 1'b0;
        bus.flag_din      = 4'b0000;
        bus.err_collision = 1'b0;
        if (!reset) begin
            if (mc_fin) begin
                bus.flag_wr  = 1'b1;
                bus.flag_din = bus.mc_flags;
            end else if (!pend && bus.alu_setflags) begin
                bus.flag_wr       = 1'b1;
                bus.flag_din      = bus.alu_flags;
                bus.err_collision = bus.sw_wr;
            end else if (!pend && bus.sw_wr) begin
                bus.flag_wr  = 1'b1;
                bus.flag_din = bus.sw_flags;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_to_d = err_to_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mc_issue) begin
                    state_d = ST_PEND;
                    cnt_d   = '0;
                end
            end
            ST_PEND: begin
                if (bus.mc_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

endmodule
